cam_capture_444: RTL and testbench
==================================

# cam_capture_444

Pixel-capture stage between the OV7670 parallel port and the dual-port frame buffer. It synchronises to VSYNC and assembles each pair of RGB565 bytes gated by HREF into one RGB444 word. Each word goes to a linear buffer address with a one-cycle write strobe. The block also checks frame geometry and reports frame completion and errors. It runs entirely in the camera pixel-clock domain; its RAM-side outputs feed the buffer write port directly.

## Interface
- AW, 15, buffer address width
- DW, 12, pixel word width (RGB444)
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- CAM_pclk  in  1  camera pixel clock; sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- CAM_vsync  in  1  frame sync, high during vertical blank
- CAM_href  in  1  line valid, high while pixel bytes are on the bus
- CAM_px_data  in  8  pixel byte bus
- DP_RAM_regW  out  1  write enable to buffer, one-cycle pulse per pixel
- DP_RAM_addr_in  out  AW  write address
- DP_RAM_data_in  out  DW  pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse at end of each captured frame
- frame_err  out  1  geometry error of the last finished frame; updated with frame_done

## Operation
- States:
  - S_SYNC: wait for vsync=1. This is the reset state; a partial frame is never captured.
  - S_BLANK: wait for vsync=0, then go to S_B1. Clear pixel address, line count, per-line pixel count and the error accumulator.
  - S_B1: while href=1, latch byte1 and go to S_B2.
  - S_B2: while href=1, compose, write and return to S_B1. If href=0, drop the orphan byte, set the error accumulator and go to S_B1.
- Conversion: with b1 = RRRRRGGG and b2 = GGGBBBBB, R=b1[7:4], G={b1[2:0],b2[7]}, B=b2[4:1].
- Address: linear, starts at 0 per frame and increments after each write.
  - If address = IMG_W*IMG_H, suppress the write, hold the address and set the error.
  - Address never wraps.
- Line check:
  - On each href falling edge (registered href=1, current href=0), compare the per-line pixel count with IMG_W. On mismatch, set the error.
  - Then increment the line count and clear the per-line count.
- Frame end: vsync=1 seen in S_B1 or S_B2.
  - Pulse frame_done.
  - frame_err <= accumulator OR (line count != IMG_H) OR (pixel count != IMG_W*IMG_H).
  - Next state is S_BLANK.
- Simultaneous events:
  - vsync rising in the same cycle as a second byte: the pixel is NOT written and counts as orphaned (error set).
  - Frame end takes priority over the href falling-edge check in the same cycle; that final line is still compared.
- Reset values: regW=0, addr=0, data=0, frame_done=0, frame_err=0, state=S_SYNC, all counters 0.
- Reset mid-frame aborts immediately with no further writes. Capture resumes only after the next full vsync high/low sequence.

## Timing
- Byte2 sampled at edge k → regW=1, addr and data valid from edge k (registered outputs); the buffer samples at edge k+1.
- regW is never high on two consecutive cycles. Minimum write spacing is 2 cycles.
- frame_done goes high the cycle after vsync is first sampled high; frame_err changes in the same cycle.
- href and vsync are sampled directly with no input synchroniser; they are source-synchronous to CAM_pclk.
- Throughput: 1 pixel per 2 pclk with no stalls. The buffer write port has no backpressure.

## Structure
- Shared package cam_pkg holds:
  - state enum (S_SYNC, S_BLANK, S_B1, S_B2)
  - default IMG_W/IMG_H/AW/DW constants
  - FRAME_PIX = IMG_W*IMG_H
- One combinational sub-module, rgb565_to_rgb444 (two bytes in, 12-bit word out), shared with future test-pattern sources.
- Counters: pixel address AW bits, line count 8 bits, per-line count 9 bits.

## Test plan
- Nominal frame: 160×120 lines of bytes 0xF8,0x1F → 19200 writes at addresses 0..19199, data 0xF0F; one frame_done, frame_err=0.
- Conversion: bytes 0x07,0xE0 → data 0x0F0; bytes 0x00,0x1F → 0x00F; bytes 0xFF,0xFF → 0xFFF.
- Partial first frame: release reset with vsync=0 mid-line → no writes until vsync pulses high then low; first write at addr 0.
- Odd byte: line 5 carries 321 bytes → 160 writes that line, orphan dropped, frame_done with frame_err=1; next clean frame gives frame_err=0.
- Overflow: 121 lines of 160 pixels → writes stop at addr 19199, regW stays 0 afterwards, frame_err=1.
- Reset mid-frame: assert rst after 1000 pixels → regW=0 and addr=0 from the next edge; next clean frame writes 0..19199 with frame_err=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: capture FSM states and
// default frame geometry / bus widths.
package cam_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_BLANK,
    S_B1,
    S_B2
  } state_t;

  localparam int CAM_AW    = 15;
  localparam int CAM_DW    = 12;
  localparam int CAM_IMG_W = 160;
  localparam int CAM_IMG_H = 120;
  localparam int FRAME_PIX = CAM_IMG_W * CAM_IMG_H;

endpackage

// File: rtl/rgb565_to_rgb444.sv
// Combinational RGB565 byte pair to RGB444 word. byte1 = RRRRRGGG,
// byte2 = GGGBBBBB; each channel keeps its four most significant bits.
module rgb565_to_rgb444 (
  input  logic [7:0]  byte1,
  input  logic [7:0]  byte2,
  output logic [11:0] pix
);

  // Low-order channel bits are intentionally discarded by the truncation.
  logic unused_lsbs;
  assign unused_lsbs = ^{byte1[3], byte2[6:5], byte2[0]};

  // Pick the top four bits of R, G and B out of the two bytes.
  always_comb begin
    pix = {byte1[7:4], byte1[2:0], byte2[7], byte2[4:1]};
  end

endmodule

// File: rtl/cam_capture_444.sv
// OV7670 pixel capture: locks to VSYNC, pairs HREF-gated RGB565 bytes into
// RGB444 words, writes them to a linear frame buffer address and reports
// per-frame completion and geometry errors. Single clock domain (CAM_pclk).
module cam_capture_444
  import cam_pkg::*;
#(
  parameter int AW    = CAM_AW,
  parameter int DW    = CAM_DW,
  parameter int IMG_W = CAM_IMG_W,
  parameter int IMG_H = CAM_IMG_H
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          frame_err
);

  localparam logic [AW-1:0] ADDR_FULL  = AW'(IMG_W * IMG_H);
  localparam logic [7:0]    LINE_TOTAL = 8'(IMG_H);
  localparam logic [8:0]    LINE_PIX   = 9'(IMG_W);

  state_t        state;
  logic [7:0]    byte1;
  logic          href_q;
  logic [AW-1:0] pix_addr;
  logic [7:0]    line_cnt;
  logic [8:0]    line_px;
  logic          err_acc;
  logic [11:0]   pix_444;

  logic          href_fall;
  logic          line_bad;
  logic [7:0]    lines_seen;
  logic          end_err;

  rgb565_to_rgb444 u_conv (
    .byte1 (byte1),
    .byte2 (CAM_px_data),
    .pix   (pix_444)
  );

  // Line-end detection and the frame verdict; a line ending in the same
  // cycle as frame end is folded in here so it is still checked, and being
  // in S_B2 at frame end means an unpaired byte was left behind.
  always_comb begin
    href_fall  = href_q & ~CAM_href;
    line_bad   = href_fall && (line_px != LINE_PIX);
    lines_seen = line_cnt + 8'(href_fall);
    end_err    = err_acc | line_bad | (state == S_B2) |
                 (lines_seen != LINE_TOTAL) | (pix_addr != ADDR_FULL);
  end

  // Capture FSM with counters and registered buffer-side outputs.
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state          <= S_SYNC;
      href_q         <= 1'b0;
      byte1          <= 8'd0;
      pix_addr       <= '0;
      line_cnt       <= 8'd0;
      line_px        <= 9'd0;
      err_acc        <= 1'b0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      href_q      <= CAM_href;
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_SYNC: begin
          if (CAM_vsync) state <= S_BLANK;
        end
        S_BLANK: begin
          pix_addr <= '0;
          line_cnt <= 8'd0;
          line_px  <= 9'd0;
          err_acc  <= 1'b0;
          if (!CAM_vsync) state <= S_B1;
        end
        S_B1, S_B2: begin
          if (CAM_vsync) begin
            frame_done <= 1'b1;
            frame_err  <= end_err;
            state      <= S_BLANK;
          end else begin
            if (href_fall) begin
              if (line_bad) err_acc <= 1'b1;
              line_cnt <= line_cnt + 8'd1;
              line_px  <= 9'd0;
            end
            if (state == S_B1) begin
              if (CAM_href) begin
                byte1 <= CAM_px_data;
                state <= S_B2;
              end
            end else if (CAM_href) begin
              // href is high here, so this never collides with the line clear.
              line_px <= line_px + 9'd1;
              if (pix_addr == ADDR_FULL) begin
                err_acc <= 1'b1;
              end else begin
                DP_RAM_regW    <= 1'b1;
                DP_RAM_addr_in <= pix_addr;
                DP_RAM_data_in <= DW'(pix_444);
                pix_addr       <= pix_addr + AW'(1);
              end
              state <= S_B1;
            end else begin
              err_acc <= 1'b1;
              state   <= S_B1;
            end
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_444.sv
// Bench for cam_capture_444 using a reduced 32x24 frame geometry.
module tb_cam_capture_444;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int W     = 32;
  localparam int H     = 24;
  localparam int FRAME = W * H;

  logic          CAM_pclk = 1'b0;
  logic          rst = 1'b1;
  logic          CAM_vsync = 1'b0;
  logic          CAM_href = 1'b0;
  logic [7:0]    CAM_px_data = 8'd0;
  logic          DP_RAM_regW;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          frame_done;
  logic          frame_err;

  cam_capture_444 #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .CAM_pclk       (CAM_pclk),
    .rst            (rst),
    .CAM_vsync      (CAM_vsync),
    .CAM_href       (CAM_href),
    .CAM_px_data    (CAM_px_data),
    .DP_RAM_regW    (DP_RAM_regW),
    .DP_RAM_addr_in (DP_RAM_addr_in),
    .DP_RAM_data_in (DP_RAM_data_in),
    .frame_done     (frame_done),
    .frame_err      (frame_err)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  int          total = 0;
  int          bad = 0;
  logic [14:0] q_addr[$];
  logic [11:0] q_data[$];
  int          m_addr;
  bit          m_err;
  bit          done_pending = 1'b0;
  bit          exp_ferr = 1'b0;
  bit          prev_regw = 1'b0;
  int          wr_cnt = 0;
  logic [7:0]  tab1[4] = '{8'hF8, 8'h07, 8'h00, 8'hFF};
  logic [7:0]  tab2[4] = '{8'h1F, 8'hE0, 8'h1F, 8'hFF};

  // Reference conversion: keep the top four bits of each 5/6/5 channel.
  function automatic logic [11:0] conv(input logic [7:0] b1, input logic [7:0] b2);
    int r, g, b;
    r = b1 / 16;
    g = (b1 % 8) * 2 + b2 / 128;
    b = (b2 / 2) % 16;
    return 12'(r * 256 + g * 16 + b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (DP_RAM_regW === 1'b1) begin
      wr_cnt++;
      chk("regw_spacing", {31'd0, prev_regw}, 32'd0);
      chk("write_expected", {31'd0, (q_addr.size() != 0)}, 32'd1);
      if (q_addr.size() != 0) begin
        chk("wr_addr", {17'd0, DP_RAM_addr_in}, {17'd0, q_addr.pop_front()});
        chk("wr_data", {20'd0, DP_RAM_data_in}, {20'd0, q_data.pop_front()});
      end
    end
    prev_regw = (DP_RAM_regW === 1'b1);
    if (frame_done === 1'b1) begin
      chk("done_expected", {31'd0, done_pending}, 32'd1);
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      done_pending = 1'b0;
    end
  endtask

  task automatic step(input bit vs, input bit hr, input logic [7:0] d);
    CAM_vsync   = vs;
    CAM_href    = hr;
    CAM_px_data = d;
    @(posedge CAM_pclk);
    #1;
    observe();
  endtask

  // Vertical sync pulse; the previous frame's verdict arrives during it.
  task automatic vs_pulse(input bit check);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom));
    if (check) begin
      chk("frame_done_seen", {31'd0, done_pending}, 32'd0);
      chk("queue_drained", q_addr.size(), 32'd0);
      chk("frame_writes", wr_cnt, m_addr);
      chk("frame_err_hold", {31'd0, frame_err}, {31'd0, exp_ferr});
    end
  endtask

  // mode 0: random bytes, 1: fixed 0xF8/0x1F, 2: conversion table.
  task automatic send_frame(input int nlines, input int odd_line, input int mode, input int rst_pix);
    int pix;
    bit cap;
    logic [7:0] b1, b2;
    pix = 0;
    cap = 1'b1;
    m_addr = 0;
    m_err = 1'b0;
    wr_cnt = 0;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < W; p++) begin
        case (mode)
          1: begin b1 = 8'hF8; b2 = 8'h1F; end
          2: begin b1 = tab1[p % 4]; b2 = tab2[p % 4]; end
          default: begin b1 = 8'($urandom); b2 = 8'($urandom); end
        endcase
        step(1'b0, 1'b1, b1);
        if (cap) begin
          if (m_addr < FRAME) begin
            q_addr.push_back(15'(m_addr));
            q_data.push_back(conv(b1, b2));
            m_addr++;
          end else begin
            m_err = 1'b1;
          end
        end
        step(1'b0, 1'b1, b2);
        pix++;
        if (pix == rst_pix) begin
          rst = 1'b1;
          step(1'b0, 1'b1, 8'($urandom));
          chk("rst_regw", {31'd0, DP_RAM_regW}, 32'd0);
          chk("rst_addr", {17'd0, DP_RAM_addr_in}, 32'd0);
          chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
          rst = 1'b0;
          cap = 1'b0;
        end
      end
      if (l == odd_line) begin
        step(1'b0, 1'b1, 8'($urandom));
        m_err = 1'b1;
      end
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 8'($urandom));
    end
    if (nlines != H) m_err = 1'b1;
    if (m_addr != FRAME) m_err = 1'b1;
    done_pending = cap;
    if (cap) exp_ferr = m_err;
    else exp_ferr = 1'b0;
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    chk("reset_regw", {31'd0, DP_RAM_regW}, 32'd0);
    chk("reset_addr", {17'd0, DP_RAM_addr_in}, 32'd0);
    chk("reset_data", {20'd0, DP_RAM_data_in}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);

    // Release reset mid-line with vsync low: nothing may be captured
    rst = 1'b0;
    m_addr = 0;
    wr_cnt = 0;
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 2 * W; b++) step(1'b0, 1'b1, 8'($urandom));
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 8'h00);
    end
    vs_pulse(1'b1);

    // Nominal frame, fixed bytes
    send_frame(H, -1, 1, -1);
    vs_pulse(1'b1);
    // Conversion table frame
    send_frame(H, -1, 2, -1);
    vs_pulse(1'b1);
    // Random clean frame
    send_frame(H, -1, 0, -1);
    vs_pulse(1'b1);
    // Odd byte count on line 5, then a clean frame
    send_frame(H, 5, 0, -1);
    vs_pulse(1'b1);
    send_frame(H, -1, 0, -1);
    vs_pulse(1'b1);
    // Too few lines
    send_frame(H - 1, -1, 0, -1);
    vs_pulse(1'b1);
    // One line too many: writes stop at the last address
    send_frame(H + 1, -1, 0, -1);
    vs_pulse(1'b1);
    // Reset mid-frame, then a clean frame
    send_frame(H, -1, 0, 300);
    vs_pulse(1'b1);
    send_frame(H, -1, 0, -1);
    vs_pulse(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
